seq_mul64: RTL and testbench



---
 rtl/seq_mul64.sv | 151 +++++++++++++++
 tb/tb_seq_mul64.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seq_mul64.sv
// seq_mul64: iterative radix-2 shift-add multiplier for the RV64M multiply group
// (MUL, MULH, MULHSU, MULHU). Signed operands are reduced to magnitudes at accept,
// multiplied unsigned over XLEN iterations, and the sign is reapplied in FIX.
module seq_mul64 #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  hi_acc;
  logic [XLEN-1:0]  mplier;
  logic [XLEN-1:0]  mcand;
  logic             neg_flag;
  logic [1:0]       op_q;

  logic             accept;
  logic             a_signed, b_signed;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag;
  logic [XLEN:0]    step_sum;
  logic [2*XLEN-1:0] product;
  logic [2*XLEN-1:0] product_fix;

  // Magnitude of a two's-complement value; -2^(XLEN-1) maps to 2^(XLEN-1),
  // which is representable because the result is read as unsigned.
  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] v, input logic neg);
    logic [XLEN-1:0] r;
    r = neg ? (~v + 1'b1) : v;
    return r;
  endfunction

  // Two's-complement negation of the full double-width product when the sign is negative.
  function automatic logic [2*XLEN-1:0] apply_sign(input logic [2*XLEN-1:0] p, input logic neg);
    logic [2*XLEN-1:0] r;
    r = neg ? (~p + 1'b1) : p;
    return r;
  endfunction

  assign accept = in_valid & in_ready;

  // Operand sign interpretation and magnitude extraction for the incoming request
  always_comb begin
    a_signed = (op == OP_MULH) || (op == OP_MULHSU);
    b_signed = (op == OP_MULH);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = mag(a, a_neg);
    b_mag    = mag(b, b_neg);
  end

  // One shift-add step: conditionally add the multiplicand into the upper half
  always_comb begin
    step_sum    = {1'b0, hi_acc} + (mplier[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
    product     = {hi_acc, mplier};
    product_fix = apply_sign(product, neg_flag);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_CALC;
      S_CALC: if (cnt == CNT_W'(XLEN-1)) state_nxt = S_FIX;
      S_FIX:  state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from the state
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_CALC: busy     = 1'b1;
      S_FIX:  busy     = 1'b1;
      S_DONE: done     = 1'b1;
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, iterate in CALC, load result in FIX
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      hi_acc   <= '0;
      mplier   <= '0;
      mcand    <= '0;
      neg_flag <= 1'b0;
      op_q     <= 2'b00;
      result   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt      <= '0;
            hi_acc   <= '0;
            mplier   <= b_mag;
            mcand    <= a_mag;
            neg_flag <= a_neg ^ b_neg;
            op_q     <= op;
          end
        end
        S_CALC: begin
          hi_acc <= step_sum[XLEN:1];
          mplier <= {step_sum[0], mplier[XLEN-1:1]};
          cnt    <= cnt + 1'b1;
        end
        S_FIX: begin
          if (op_q == OP_MUL) result <= product_fix[XLEN-1:0];
          else                result <= product_fix[2*XLEN-1:XLEN];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul64.sv
// Directed bench for seq_mul64: a vector table of operations with hand-computed
// products, plus sequences for ignored requests and reset during an operation.
module tb_seq_mul64;

  localparam int XLEN = 64;

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  int errors = 0;
  int checks = 0;

  seq_mul64 #(.XLEN(XLEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [1:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  // Issue one op from a negedge, then count edges (accept edge = 1) until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [XLEN-1:0] x, input logic [XLEN-1:0] y,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    busy_cnt = 0;
    @(negedge clk);
    in_valid = 1'b0;
    a = '1; b = '1; op = 2'b11;
    while (!done && lat < 200) begin
      if (busy) busy_cnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    int lat;
    int bc;
    int done_seen;

    vecs[0]  = '{"mul_3x5",        2'b00, 64'd3,                  64'd5,                  64'h000000000000000F};
    vecs[1]  = '{"mulh_min_min",   2'b01, 64'h8000000000000000,   64'h8000000000000000,   64'h4000000000000000};
    vecs[2]  = '{"mulhu_ones",     2'b11, 64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFE};
    vecs[3]  = '{"mulh_ones",      2'b01, 64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   64'h0000000000000000};
    vecs[4]  = '{"mul_ones",       2'b00, 64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   64'h0000000000000001};
    vecs[5]  = '{"mulhsu_m1_umax", 2'b10, 64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF,   64'hFFFFFFFFFFFFFFFF};
    vecs[6]  = '{"mulh_m3x5",      2'b01, 64'hFFFFFFFFFFFFFFFD,   64'd5,                  64'hFFFFFFFFFFFFFFFF};
    vecs[7]  = '{"mul_m3x5",       2'b00, 64'hFFFFFFFFFFFFFFFD,   64'd5,                  64'hFFFFFFFFFFFFFFF1};
    vecs[8]  = '{"mulhu_2p63x4",   2'b11, 64'h8000000000000000,   64'd4,                  64'h0000000000000002};
    vecs[9]  = '{"mulh_min_x1",    2'b01, 64'h8000000000000000,   64'd1,                  64'hFFFFFFFFFFFFFFFF};
    vecs[10] = '{"mul_zero",       2'b00, 64'd0,                  64'h123456789ABCDEF0,   64'h0000000000000000};

    rst = 1'b1; in_valid = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);
    check("reset_busy",     {63'd0, busy},     64'd0);
    check("reset_done",     {63'd0, done},     64'd0);
    check("reset_result",   result,            64'd0);
    rst = 1'b0;

    // Table-driven products, each with the fixed latency checked
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bc);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'd66);
      check({vecs[i].name, "_result"},  result,   vecs[i].exp);
      if (i == 0) check("mul_3x5_busy_cycles", 64'(bc), 64'd65);
      @(negedge clk);
      check({vecs[i].name, "_done_one_cycle"}, {63'd0, done}, 64'd0);
      check({vecs[i].name, "_ready_after"},    {63'd0, in_ready}, 64'd1);
    end

    // Request while busy is ignored and not queued
    @(negedge clk);
    op = 2'b00; a = 64'd7; b = 64'd6; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    done_seen = 0;
    while (!done && lat < 200) begin
      if (lat == 10) begin a = 64'd2; b = 64'd2; in_valid = 1'b1; end
      if (lat == 14) in_valid = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("ignore_latency", 64'(lat), 64'd66);
    check("ignore_result",  result,   64'd42);
    @(negedge clk);
    check("ignore_ready_after", {63'd0, in_ready}, 64'd1);
    for (int k = 0; k < 80; k++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("ignore_no_second_done", 64'(done_seen), 64'd0);
    check("ignore_result_held",    result,         64'd42);

    // Reset during CALC discards the operation
    op = 2'b00; a = 64'd9; b = 64'd9; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    check("rst_mid_busy_before", {63'd0, busy}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_mid_busy",     {63'd0, busy},     64'd0);
    check("rst_mid_result",   result,            64'd0);
    done_seen = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("rst_mid_no_done", 64'(done_seen), 64'd0);

    // Normal operation resumes after the aborted one
    run_op(2'b11, 64'hFFFFFFFFFFFFFFFF, 64'd2, lat, bc);
    check("post_rst_latency", 64'(lat), 64'd66);
    check("post_rst_result",  result,   64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
